aes_req_arbiter: RTL and testbench
==================================

Name: aes_req_arbiter

Overview:
- Shares one AES_top encryption core among NUM_REQ requesters.
- Selects requesters round-robin and holds the core enable asserted for the whole job.
- Captures the core result and returns it with the requester ID over a valid/ready response channel.
- A watchdog aborts hung jobs, pulses the core's active-low reset and returns an error response.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); ID_W = clog2(NUM_REQ).
- TIMEOUT, 64, maximum BUSY cycles allowed before a job is aborted.
- RST_CYCLES, 2, number of cycles core_rst_n is held low on abort.

Ports:
- AES_clk  in  1  clock; all logic on rising edge.
- AES_rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- req_data  in  NUM_REQ*128  plaintext, requester i at bits [128i+127:128i].
- req_key  in  NUM_REQ*128  key, same packing as req_data.
- core_rst_n  out  1  active-low reset to the AES core.
- core_en  out  1  to AES_en.
- core_data_in  out  128  to AES_data_in.
- core_key_in  out  128  to AES_key_in.
- core_data_out  in  128  from AES_data_out.
- core_data_out_valid  in  1  from AES_data_out_valid.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_data  out  128  ciphertext; 0 when rsp_err=1.
- rsp_err  out  1  job aborted by timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (AES_rst=1 at an edge):
  - state=IDLE, rr_ptr=0.
  - All outputs 0, except core_rst_n=0 during the reset cycles.
  - Reset mid-job drops the job silently; no response is issued.
- FSM states: IDLE, BUSY, FLUSH, RESP.
- IDLE:
  - Winner g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle; all other ready bits are 0.
  - On that edge, capture req_data[g] and req_key[g] into the job registers, set rsp_id=g, clear the cycle counter, and go to BUSY.
  - If no req_valid is high, remain in IDLE.
  - req_ready is 0 in every state other than IDLE.
- BUSY:
  - core_en=1; core_data_in and core_key_in are driven from the job registers and are stable for the whole state.
  - Counter increments every cycle.
  - If core_data_out_valid=1: capture core_data_out into rsp_data, set rsp_err=0, go to RESP.
  - Else if counter==TIMEOUT-1: go to FLUSH with rsp_err=1 and rsp_data=0.
  - If valid and timeout occur in the same cycle, valid wins.
- FLUSH:
  - core_en=0; core_rst_n=0 for exactly RST_CYCLES cycles, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable until rsp_ready=1.
  - On the handshake edge: rr_ptr=(rsp_id+1) mod NUM_REQ, go to IDLE.
  - core_en=0 in RESP; the core input registers keep their last value.
- Timing:
  - Accept at edge T.
  - core_en is high in cycles T+1 .. V, where V is the cycle in which core_data_out_valid is seen.
  - rsp_valid rises at V+1.
  - Minimum idle-to-idle turnaround = core latency + 2 cycles.
- Out-of-state core signals: core_data_out_valid in IDLE, FLUSH or RESP is ignored and does not affect rsp_data.
- Fixed input packing: requester i owns slice i of req_data and req_key.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 jobs.

Test Plan:
- Single job, basic path:
  - Stimulus: bench core model returns data^key with valid 20 cycles after en rises. Requester 0 sends data=0000009e_00000000_00000000_00000000, key=aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc.
  - Required: req_ready[0] pulses for 1 cycle; core_en high for 20 cycles; rsp_valid one cycle after core valid with rsp_id=0, rsp_data=aa2bdb de_bff6a5e8_caa9ba3e_bc1e2acc (i.e. data^key), rsp_err=0.
- Round-robin:
  - Stimulus: req_valid=4'b1111 held for 4 jobs, rsp_ready=1.
  - Required: grant order 0,1,2,3; a following fifth job grants 0 again.
- Backpressure:
  - Stimulus: rsp_ready=0 for 10 cycles after rsp_valid rises.
  - Required: response fields stable throughout; req_ready stays 0; next grant occurs only after the handshake.
- Timeout:
  - Stimulus: core model never asserts valid; TIMEOUT=64.
  - Required: core_en high for exactly 64 cycles; core_rst_n low for 2 cycles; rsp_err=1, rsp_data=0; busy stays high until the handshake.
- Simultaneous events:
  - Stimulus: core valid arrives in the same cycle the counter reaches TIMEOUT-1.
  - Required: rsp_err=0, rsp_data equals the core output, FLUSH is never entered.
- Reset mid-BUSY:
  - Stimulus: assert AES_rst for 1 cycle partway through a job.
  - Required: next cycle all outputs are 0 and state is IDLE; no rsp_valid for the dropped job; next grant goes to requester 0.

Source files
------------

// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter that shares one AES core among NUM_REQ requesters. A
// watchdog aborts hung jobs, resets the core and returns an error response.
//
// state | meaning
// IDLE  | no job; grant the next requester in round-robin order
// BUSY  | core enabled with the captured job, watchdog counting down
// FLUSH | job aborted; core held in reset for RST_CYCLES cycles
// RESP  | response held on the rsp channel until rsp_ready

module aes_req_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int TIMEOUT    = 64,
    parameter  int RST_CYCLES = 2,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                     AES_clk,
    input  logic                     AES_rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*128-1:0]   req_data,
    input  logic [NUM_REQ*128-1:0]   req_key,
    output logic                     core_rst_n,
    output logic                     core_en,
    output logic [127:0]             core_data_in,
    output logic [127:0]             core_key_in,
    input  logic [127:0]             core_data_out,
    input  logic                     core_data_out_valid,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [127:0]             rsp_data,
    output logic                     rsp_err,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, BUSY, FLUSH, RESP} state_t;

    localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t            state_q;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [127:0]      job_data_q;
    logic [127:0]      job_key_q;
    logic [127:0]      rsp_data_q;
    logic              rsp_err_q;
    logic              core_rst_n_q;

    logic              grant_vld_d;
    logic [ID_W-1:0]   grant_idx_d;
    logic [ID_W-1:0]   cand_d;

    // Scan starts at rr_ptr and wraps; the first requester found wins.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_idx_d = '0;
        cand_d      = '0;
        req_ready   = '0;
        if (state_q == IDLE && !AES_rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand_d = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
                if (!grant_vld_d && req_valid[cand_d]) begin
                    grant_vld_d = 1'b1;
                    grant_idx_d = cand_d;
                end
            end
            if (grant_vld_d) begin
                req_ready[grant_idx_d] = 1'b1;
            end
        end
    end

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            rsp_id_q     <= '0;
            cnt_q        <= '0;
            job_data_q   <= '0;
            job_key_q    <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            core_rst_n_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (grant_vld_d) begin
                        job_data_q <= req_data[grant_idx_d*128 +: 128];
                        job_key_q  <= req_key[grant_idx_d*128 +: 128];
                        rsp_id_q   <= grant_idx_d;
                        cnt_q      <= CNT_W'(TIMEOUT - 1);
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    // A result arriving on the last allowed cycle still counts.
                    if (core_data_out_valid) begin
                        rsp_data_q <= core_data_out;
                        rsp_err_q  <= 1'b0;
                        state_q    <= RESP;
                    end else if (cnt_q == '0) begin
                        rsp_data_q   <= '0;
                        rsp_err_q    <= 1'b1;
                        cnt_q        <= CNT_W'(RST_CYCLES - 1);
                        core_rst_n_q <= 1'b0;
                        state_q      <= FLUSH;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FLUSH: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q        <= cnt_q - 1'b1;
                        core_rst_n_q <= 1'b0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rr_ptr_q <= (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign core_en      = (state_q == BUSY);
    assign core_rst_n   = core_rst_n_q;
    assign core_data_in = job_data_q;
    assign core_key_in  = job_key_q;
    assign rsp_valid    = (state_q == RESP);
    assign rsp_id       = rsp_id_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Bench for aes_req_arbiter: bench-side AES core model, job-timeline reference
// model checked every cycle, plus directed scenarios with literal expectations.

module tb_aes_req_arbiter;

    localparam int NUM  = 4;
    localparam int TMO  = 64;
    localparam int RSTC = 2;
    localparam int M_IDLE = 0, M_JOB = 1, M_FLUSH = 2, M_RESP = 3;

    logic             AES_clk = 1'b0;
    logic             AES_rst;
    logic [NUM-1:0]   req_valid;
    logic [NUM-1:0]   req_ready;
    logic [NUM*128-1:0] req_data;
    logic [NUM*128-1:0] req_key;
    logic             core_rst_n;
    logic             core_en;
    logic [127:0]     core_data_in;
    logic [127:0]     core_key_in;
    logic [127:0]     core_data_out;
    logic             core_data_out_valid;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [1:0]       rsp_id;
    logic [127:0]     rsp_data;
    logic             rsp_err;
    logic             busy;

    aes_req_arbiter #(.NUM_REQ(NUM), .TIMEOUT(TMO), .RST_CYCLES(RSTC)) dut (
        .AES_clk(AES_clk), .AES_rst(AES_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_key(req_key),
        .core_rst_n(core_rst_n), .core_en(core_en),
        .core_data_in(core_data_in), .core_key_in(core_key_in),
        .core_data_out(core_data_out), .core_data_out_valid(core_data_out_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 AES_clk = ~AES_clk;

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle_no);
        end
    endtask

    function automatic int pick(input logic [NUM-1:0] v, input int rr);
        for (int k = 0; k < NUM; k++) begin
            if (v[(rr + k) % NUM]) return (rr + k) % NUM;
        end
        return -1;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference model: job timeline in absolute cycle numbers.
    int           m_mode = M_IDLE;
    int           m_rr = 0;
    int           m_T = 0;
    int           m_flush_end = 0;
    int           m_rid = 0;
    int           m_g;
    bit           m_post_rst = 1'b0;
    bit           model_ok = 1'b0;
    logic [127:0] m_jd = '0, m_jk = '0, m_rdata = '0;
    bit           m_rerr = 1'b0;

    always @(posedge AES_clk) begin
        if (AES_rst) begin
            m_mode = M_IDLE; m_rr = 0; m_rid = 0;
            m_jd = '0; m_jk = '0; m_rdata = '0; m_rerr = 1'b0;
            m_post_rst = 1'b1; model_ok = 1'b1;
        end else if (model_ok) begin
            m_post_rst = 1'b0;
            case (m_mode)
                M_IDLE: begin
                    m_g = pick(req_valid, m_rr);
                    if (m_g >= 0) begin
                        m_jd = req_data[m_g*128 +: 128];
                        m_jk = req_key[m_g*128 +: 128];
                        m_rid = m_g; m_T = cycle_no; m_mode = M_JOB;
                    end
                end
                M_JOB: begin
                    if (core_data_out_valid) begin
                        m_rdata = core_data_out; m_rerr = 1'b0; m_mode = M_RESP;
                    end else if (cycle_no - m_T == TMO) begin
                        m_rdata = '0; m_rerr = 1'b1; m_mode = M_FLUSH;
                        m_flush_end = cycle_no + RSTC;
                    end
                end
                M_FLUSH: if (cycle_no == m_flush_end) m_mode = M_RESP;
                default: if (rsp_ready) begin
                    m_rr = (m_rid + 1) % NUM; m_mode = M_IDLE;
                end
            endcase
        end
        cycle_no++;
    end

    logic [NUM-1:0] exp_ready;
    int             cg;

    always @(negedge AES_clk) begin
        if (model_ok) begin
            cg = pick(req_valid, m_rr);
            exp_ready = (m_mode == M_IDLE && !AES_rst && cg >= 0) ? (NUM'(1) << cg) : '0;
            chk("req_ready", req_ready, exp_ready);
            chk("busy", busy, m_mode != M_IDLE);
            chk("core_en", core_en, m_mode == M_JOB);
            chk("core_rst_n", core_rst_n, !(m_post_rst || m_mode == M_FLUSH));
            chk("rsp_valid", rsp_valid, m_mode == M_RESP);
            chk("core_data_in", core_data_in, m_jd);
            chk("core_key_in", core_key_in, m_jk);
            if (m_mode == M_RESP || m_post_rst) begin
                chk("rsp_id", rsp_id, m_rid[1:0]);
                chk("rsp_data", rsp_data, m_rdata);
                chk("rsp_err", rsp_err, m_rerr);
            end
        end
    end

    // Observation counters for the directed scenarios.
    int           en_mon = 0, rstn_low_mon = 0, rv_mon = 0, ready_mon = 0, rsp_cnt = 0;
    int           grants[$];
    logic [1:0]   last_id;
    logic [127:0] last_data;
    logic         last_err;

    always @(negedge AES_clk) begin
        if (core_en) en_mon++;
        if (!core_rst_n) rstn_low_mon++;
        if (rsp_valid) rv_mon++;
        if (req_ready != '0) ready_mon++;
        for (int i = 0; i < NUM; i++) if (req_ready[i]) grants.push_back(i);
        if (rsp_valid && rsp_ready) begin
            last_id = rsp_id; last_data = rsp_data; last_err = rsp_err;
            rsp_cnt++;
        end
    end

    task automatic clear_mon();
        en_mon = 0; rstn_low_mon = 0; rv_mon = 0; ready_mon = 0;
        grants.delete();
    endtask

    // Bench core model and response sink.
    int lat = 20, cur_lat = 20, en_run = 0, rv_run = 0, rdy_mode = 0, hold = 0, rsel;
    bit noise = 1'b0, rand_lat = 1'b0;

    initial begin
        core_data_out_valid = 1'b0;
        core_data_out = '0;
        rsp_ready = 1'b0;
        forever begin
            @(posedge AES_clk);
            #2;
            if (core_en) begin
                en_run++;
                if (en_run == 1) begin
                    cur_lat = lat;
                    if (rand_lat) begin
                        rsel = $urandom_range(0, 9);
                        cur_lat = (rsel == 0) ? TMO : (rsel == 1) ? 1000 :
                                  (rsel == 2) ? TMO - 1 : $urandom_range(1, 30);
                    end
                end
                core_data_out_valid = (en_run == cur_lat);
                core_data_out = (en_run == cur_lat) ? (core_data_in ^ core_key_in) : rand128();
            end else begin
                en_run = 0;
                core_data_out_valid = noise && ($urandom_range(0, 3) == 0);
                core_data_out = rand128();
            end
            rv_run = rsp_valid ? rv_run + 1 : 0;
            case (rdy_mode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = (rv_run > hold);
            endcase
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge AES_clk);
        #2;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n = 0;
        while (rsp_cnt < target && n < budget) begin
            @(posedge AES_clk);
            n++;
        end
        checks++;
        if (rsp_cnt < target) begin
            errors++;
            $display("FAIL wait_rsp: got %0d responses, expected %0d", rsp_cnt, target);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    int           base;
    int           exp_rr[5];
    logic [127:0] d2, k2;

    initial begin
        AES_rst = 1'b1; req_valid = '0; req_data = '0; req_key = '0;
        repeat (2) @(posedge AES_clk);
        @(negedge AES_clk);
        chk("reset core_rst_n", core_rst_n, 0);
        chk("reset busy", busy, 0);
        chk("reset core_en", core_en, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_data", rsp_data, 0);
        @(posedge AES_clk); #2;
        AES_rst = 1'b0;
        step(2);

        // Single job, core latency 20
        clear_mon(); lat = 20;
        req_data[127:0] = 128'h0000009e_00000000_00000000_00000000;
        req_key[127:0]  = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
        req_valid = 4'b0001;
        step(1);
        req_valid = '0;
        wait_rsp(1, 200); #2;
        chk("basic en cycles", en_mon, 20);
        chk("basic ready pulses", ready_mon, 1);
        chk("basic rsp_id", last_id, 0);
        chk("basic rsp_data", last_data, 128'haa2bdbde_bff6a5e8_caa9ba3e_bc1e2acc);
        chk("basic rsp_err", last_err, 0);

        // Round-robin from a fresh reset
        AES_rst = 1'b1; step(2); AES_rst = 1'b0; step(1);
        clear_mon(); lat = 5; base = rsp_cnt;
        for (int i = 0; i < NUM; i++) begin
            req_data[i*128 +: 128] = rand128();
            req_key[i*128 +: 128] = rand128();
        end
        req_valid = 4'b1111;
        wait_rsp(base + 5, 300); #2;
        req_valid = '0;
        exp_rr = '{0, 1, 2, 3, 0};
        chk("rr grant count", grants.size(), 5);
        for (int i = 0; i < 5 && i < grants.size(); i++) chk("rr grant order", grants[i], exp_rr[i]);

        // Backpressure: 10 cycles without rsp_ready per response
        clear_mon(); rdy_mode = 2; hold = 10; lat = 7; base = rsp_cnt;
        req_valid = 4'b1010;
        wait_rsp(base + 2, 300); #2;
        req_valid = '0; rdy_mode = 0;
        chk("bp rsp_valid cycles", rv_mon, 22);
        chk("bp grant count", grants.size(), 2);
        if (grants.size() == 2) begin
            chk("bp first grant", grants[0], 1);
            chk("bp second grant", grants[1], 3);
        end

        // Timeout: core never answers
        step(1); clear_mon(); lat = 1000; base = rsp_cnt;
        req_valid = 4'b0001;
        step(1);
        req_valid = '0;
        wait_rsp(base + 1, 300); #2;
        chk("tmo en cycles", en_mon, TMO);
        chk("tmo core_rst_n low cycles", rstn_low_mon, RSTC);
        chk("tmo rsp_err", last_err, 1);
        chk("tmo rsp_data", last_data, 0);
        chk("tmo rsp_id", last_id, 0);

        // Valid on the final watchdog cycle
        clear_mon(); lat = TMO; base = rsp_cnt;
        d2 = rand128(); k2 = rand128();
        req_data[255:128] = d2; req_key[255:128] = k2;
        req_valid = 4'b0010;
        step(1);
        req_valid = '0;
        wait_rsp(base + 1, 300); #2;
        chk("sim en cycles", en_mon, TMO);
        chk("sim core_rst_n low cycles", rstn_low_mon, 0);
        chk("sim rsp_err", last_err, 0);
        chk("sim rsp_data", last_data, d2 ^ k2);
        chk("sim rsp_id", last_id, 1);

        // Reset in the middle of a job
        clear_mon(); lat = 1000;
        req_valid = 4'b0100;
        step(1);
        req_valid = '0;
        step(20);
        base = rsp_cnt;
        AES_rst = 1'b1; step(1); AES_rst = 1'b0;
        step(100);
        chk("rst dropped job responses", rsp_cnt, base);
        chk("rst busy after drop", busy, 0);
        clear_mon(); lat = 3;
        req_valid = 4'b1111;
        step(1);
        req_valid = '0;
        wait_rsp(base + 1, 100); #2;
        chk("rst next grant count", grants.size(), 1);
        if (grants.size() == 1) chk("rst next grant", grants[0], 0);

        // Randomized traffic with stray core valids and random rsp_ready
        noise = 1'b1; rand_lat = 1'b1; rdy_mode = 1; base = rsp_cnt;
        repeat (3000) begin
            if ($urandom_range(0, 3) == 0) req_valid = NUM'($urandom);
            for (int i = 0; i < NUM; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    req_data[i*128 +: 128] = rand128();
                    req_key[i*128 +: 128] = rand128();
                end
            end
            step(1);
        end
        req_valid = '0; noise = 1'b0; rand_lat = 1'b0; lat = 5; rdy_mode = 0;
        step(200);
        chk("random enough responses", (rsp_cnt - base) >= 10, 1);
        chk("random drained busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
